// File: rtl/fifo_wr_pkg.sv
// Shared constants and helpers for the async-FIFO write-side packer.
package fifo_wr_pkg;

  // Width of the per-frame word counter and the frm_words report.
  localparam int FRM_CNT_W = 16;

  // Ceiling log2, minimum result 1, used to size the lane index.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_wr_hold.sv
// One-entry holding register between the lane packer and the FIFO write port.
module fifo_wr_hold #(
  parameter int DW = 32
) (
  input  logic          wclk,
  input  logic          rst_n,
  input  logic [DW-1:0] data_in,
  input  logic          last_in,
  input  logic          load,
  input  logic          w_full,
  output logic          hold_v,
  output logic [DW-1:0] hold_data,
  output logic          hold_last,
  output logic          w_en
);

  assign w_en = hold_v & ~w_full;

  // A load wins over a drain in the same cycle so the entry stays occupied.
  always_ff @(posedge wclk) begin
    if (!rst_n) begin
      hold_v    <= 1'b0;
      hold_data <= '0;
      hold_last <= 1'b0;
    end else if (load) begin
      hold_v    <= 1'b1;
      hold_data <= data_in;
      hold_last <= last_in;
    end else if (w_en) begin
      hold_v    <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_wr_packer.sv
// Packs RATIO narrow beats into one FIFO word, pads partial words at frame
// end, drives the FIFO write port and reports per-frame word counts.
module fifo_wr_packer
  import fifo_wr_pkg::*;
#(
  parameter int            IW       = 8,
  parameter int            RATIO    = 4,
  parameter int            ASIZE    = 5,
  parameter int            AFULL_TH = (1 << ASIZE) - 4,
  parameter logic [IW-1:0] PAD      = '0
) (
  input  logic                 wclk,
  input  logic                 rst_n,
  input  logic [IW-1:0]        s_data,
  input  logic                 s_valid,
  input  logic                 s_last,
  output logic                 s_ready,
  output logic [IW*RATIO-1:0]  wdata,
  output logic                 w_en,
  input  logic                 w_full,
  input  logic [ASIZE-1:0]     wuse,
  output logic                 afull,
  output logic                 frm_done,
  output logic [FRM_CNT_W-1:0] frm_words
);

  localparam int                DW        = IW * RATIO;
  localparam int                LW        = clog2(RATIO);
  localparam logic [LW-1:0]     LAST_LANE = LW'(RATIO - 1);
  localparam logic [ASIZE:0]    AFULL_LVL = (ASIZE + 1)'(AFULL_TH);

  // Saturating increment for the frame word counter.
  function automatic logic [FRM_CNT_W-1:0] sat_inc(input logic [FRM_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [LW-1:0]          lane_p0;
  logic [(RATIO-1)*IW-1:0] acc_p0;
  logic [DW-1:0]          word_p0;
  logic                   accept_p0;
  logic                   word_done_p0;
  logic                   hold_v;
  logic                   hold_last;
  logic [FRM_CNT_W-1:0]   word_cnt;

  assign s_ready      = ~hold_v | ~w_full;
  assign accept_p0    = s_valid & s_ready;
  assign word_done_p0 = accept_p0 & ((lane_p0 == LAST_LANE) | s_last);

  // Assemble the outgoing word: stored lanes below, current beat, PAD above.
  always_comb begin
    word_p0 = {RATIO{PAD}};
    for (int i = 0; i < RATIO - 1; i++) begin
      if (LW'(i) < lane_p0) word_p0[i*IW +: IW] = acc_p0[i*IW +: IW];
    end
    word_p0[lane_p0*IW +: IW] = s_data;
  end

  // Lane index and accumulator; a completed word restarts at lane 0.
  always_ff @(posedge wclk) begin
    if (!rst_n) begin
      lane_p0 <= '0;
      acc_p0  <= '0;
    end else if (word_done_p0) begin
      lane_p0 <= '0;
    end else if (accept_p0) begin
      acc_p0[lane_p0*IW +: IW] <= s_data;
      lane_p0                  <= lane_p0 + 1'b1;
    end
  end

  // ---- stage p0 -> p1: completed word enters the holding register ----
  fifo_wr_hold #(
    .DW(DW)
  ) u_hold (
    .wclk      (wclk),
    .rst_n     (rst_n),
    .data_in   (word_p0),
    .last_in   (s_last),
    .load      (word_done_p0),
    .w_full    (w_full),
    .hold_v    (hold_v),
    .hold_data (wdata),
    .hold_last (hold_last),
    .w_en      (w_en)
  );

  // Count words written in the current frame and report on its last word.
  always_ff @(posedge wclk) begin
    if (!rst_n) begin
      word_cnt  <= '0;
      frm_done  <= 1'b0;
      frm_words <= '0;
    end else begin
      frm_done <= 1'b0;
      if (w_en) begin
        if (hold_last) begin
          frm_done  <= 1'b1;
          frm_words <= sat_inc(word_cnt);
          word_cnt  <= '0;
        end else begin
          word_cnt  <= sat_inc(word_cnt);
        end
      end
    end
  end

  // Advisory almost-full flag, registered from the FIFO fill level.
  always_ff @(posedge wclk) begin
    if (!rst_n) afull <= 1'b0;
    else        afull <= ({1'b0, wuse} >= AFULL_LVL);
  end

endmodule

// File: tb/tb_fifo_wr_packer.sv
// Testbench for fifo_wr_packer: table vectors, directed corner cases,
// randomized frames against a queue-based reference and a FIFO model.
module tb_fifo_wr_packer;

  localparam int IW = 8, RATIO = 4, ASIZE = 5;

  logic        wclk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic        s_ready;
  logic [31:0] wdata;
  logic        w_en;
  logic        w_full = 1'b0;
  logic [4:0]  wuse = '0;
  logic        afull;
  logic        frm_done;
  logic [15:0] frm_words;

  always #5 wclk = ~wclk;

  fifo_wr_packer #(
    .IW(IW), .RATIO(RATIO), .ASIZE(ASIZE), .AFULL_TH(28), .PAD(8'h00)
  ) dut (
    .wclk(wclk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid),
    .s_last(s_last), .s_ready(s_ready), .wdata(wdata), .w_en(w_en),
    .w_full(w_full), .wuse(wuse), .afull(afull), .frm_done(frm_done),
    .frm_words(frm_words)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_words[$];
  int          exp_frm[$];
  logic [7:0]  part[$];
  int          frm_wcnt = 0;
  bit          use_model = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Reference: collect beats; a word closes after RATIO beats or on last.
  function automatic void model_accept(input logic [7:0] d, input bit l);
    logic [31:0] w;
    part.push_back(d);
    if (part.size() == RATIO || l) begin
      w = 32'h0;
      for (int i = 0; i < part.size(); i++) w[i*8 +: 8] = part[i];
      exp_words.push_back(w);
      part.delete();
      frm_wcnt++;
      if (l) begin
        exp_frm.push_back(frm_wcnt > 65535 ? 65535 : frm_wcnt);
        frm_wcnt = 0;
      end
    end
  endfunction

  // All driving tasks start and end at posedge+1.
  task automatic idle(input int n);
    repeat (n) begin @(posedge wclk); #1; end
  endtask

  task automatic send(input logic [7:0] d, input bit l, output int waits);
    bit ok;
    ok = 1'b0;
    waits = 0;
    s_data = d; s_last = l; s_valid = 1'b1;
    while (!ok) begin
      @(negedge wclk);
      ok = s_ready;
      @(posedge wclk); #1;
      if (ok) begin
        if (use_model) model_accept(d, l);
      end else begin
        waits++;
        if (waits > 500) begin
          $display("FAIL send_timeout: got no accept expected accept within 500 cycles");
          $fatal(1, "stalled");
        end
      end
    end
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  // Monitor: every FIFO write and frame report is checked against the queues.
  int cyc = 0;
  bit wrote = 1'b0;
  int last_wen_cyc = -1;
  bit cadence_chk = 1'b0;
  int wen_count = 0;
  bit afull_chk = 1'b0;
  bit afull_exp = 1'b0;
  bit saw_afull = 1'b0;

  always @(negedge wclk) begin
    cyc++;
    wrote = 1'b0;
    if (rst_n) begin
      if (w_en) begin
        wrote = 1'b1;
        wen_count++;
        if (exp_words.size() == 0) check("unexpected_wen", 1, 0);
        else check("wdata", wdata, exp_words.pop_front());
        if (cadence_chk && last_wen_cyc >= 0) check("wen_spacing", cyc - last_wen_cyc, 4);
        last_wen_cyc = cyc;
      end
      if (w_full) check("wen_while_full", w_en, 0);
      if (frm_done) begin
        if (exp_frm.size() == 0) check("unexpected_frm_done", 1, 0);
        else check("frm_words", frm_words, exp_frm.pop_front());
      end
      if (afull_chk) check("afull", afull, afull_exp);
      if (afull) saw_afull = 1'b1;
      afull_exp = (wuse >= 28);
    end
  end

  // FIFO occupancy model (depth 32) or random back-pressure generator.
  bit fifo_mode = 1'b0;
  bit rd_en = 1'b0;
  bit rand_full = 1'b0;
  int fcnt = 0;

  always @(posedge wclk) begin
    #1;
    if (fifo_mode) begin
      if (wrote) fcnt++;
      if (rd_en && fcnt > 0) fcnt--;
      w_full = (fcnt >= 32);
      wuse = (fcnt > 31) ? 5'd31 : 5'(fcnt);
    end else if (rand_full) begin
      w_full = ($urandom_range(0, 9) < 3);
    end
  end

  typedef struct {
    logic [7:0]  d;
    bit          last;
    bit          word_v;
    logic [31:0] word;
    int          frm;
  } vec_t;

  vec_t tv[$];

  task automatic apply_vecs(input int lo, input int hi);
    int w;
    use_model = 1'b0;
    for (int i = lo; i <= hi; i++) begin
      send(tv[i].d, tv[i].last, w);
      if (tv[i].word_v) exp_words.push_back(tv[i].word);
      if (tv[i].frm != 0) exp_frm.push_back(tv[i].frm);
    end
    use_model = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, stalls, base, t;
    logic [7:0] d;
    int len;

    // vectors: {beat, last, word_complete, word, frm_words}
    tv.push_back('{8'h01, 0, 0, 32'h0, 0});
    tv.push_back('{8'h02, 0, 0, 32'h0, 0});
    tv.push_back('{8'h03, 0, 0, 32'h0, 0});
    tv.push_back('{8'h04, 1, 1, 32'h04030201, 1});
    tv.push_back('{8'h11, 0, 0, 32'h0, 0});
    tv.push_back('{8'h12, 0, 0, 32'h0, 0});
    tv.push_back('{8'h13, 0, 0, 32'h0, 0});
    tv.push_back('{8'h14, 0, 1, 32'h14131211, 0});
    tv.push_back('{8'h15, 1, 1, 32'h00000015, 2});
    tv.push_back('{8'h21, 0, 0, 32'h0, 0});
    tv.push_back('{8'h22, 0, 0, 32'h0, 0});
    tv.push_back('{8'h23, 0, 0, 32'h0, 0});
    tv.push_back('{8'h24, 1, 1, 32'h24232221, 1});

    // reset state
    idle(2);
    rst_n = 1'b1;
    @(negedge wclk);
    check("rst_w_en", w_en, 0);
    check("rst_wdata", wdata, 0);
    check("rst_afull", afull, 0);
    check("rst_frm_done", frm_done, 0);
    check("rst_frm_words", frm_words, 0);
    check("rst_s_ready", s_ready, 1);
    @(posedge wclk); #1;

    // full word and padded tail word
    apply_vecs(0, 8);
    idle(4);

    // back-pressure with a held word
    w_full = 1'b1;
    send(8'h31, 0, w); send(8'h32, 0, w); send(8'h33, 0, w); send(8'h34, 1, w);
    base = wen_count;
    repeat (5) begin
      @(negedge wclk);
      check("full_w_en", w_en, 0);
      check("full_s_ready", s_ready, 0);
      check("full_wdata", wdata, 32'h34333231);
      @(posedge wclk); #1;
    end
    w_full = 1'b0;
    @(negedge wclk);
    check("release_w_en", w_en, 1);
    @(posedge wclk); #1;
    @(negedge wclk);
    check("after_w_en", w_en, 0);
    check("after_s_ready", s_ready, 1);
    check("release_wen_count", wen_count - base, 1);
    @(posedge wclk); #1;
    idle(3);

    // continuous 64-beat frame
    cadence_chk = 1'b1; last_wen_cyc = -1; stalls = 0; base = wen_count;
    for (int i = 0; i < 64; i++) begin
      send(8'(i + 1), i == 63, w);
      stalls += w;
    end
    idle(3);
    cadence_chk = 1'b0;
    check("stream_stalls", stalls, 0);
    check("stream_words", wen_count - base, 16);

    // reset mid-frame
    send(8'h41, 0, w); send(8'h42, 0, w);
    rst_n = 1'b0;
    part.delete(); frm_wcnt = 0;
    idle(1);
    rst_n = 1'b1;
    base = wen_count;
    @(negedge wclk);
    check("midrst_wdata", wdata, 0);
    check("midrst_frm_words", frm_words, 0);
    @(posedge wclk); #1;
    idle(4);
    check("midrst_no_wen", wen_count - base, 0);
    apply_vecs(9, 12);
    idle(4);

    // randomized frames under random back-pressure
    rand_full = 1'b1;
    for (int f = 0; f < 120; f++) begin
      len = $urandom_range(1, 10);
      for (int b = 0; b < len; b++) begin
        d = 8'($urandom);
        send(d, b == len - 1, w);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
    end
    rand_full = 1'b0;
    idle(1);
    w_full = 1'b0;
    idle(6);
    check("rand_pending_words", exp_words.size(), 0);
    check("rand_pending_frames", exp_frm.size(), 0);

    // FIFO-attached run with a paused reader
    fcnt = 0; fifo_mode = 1'b1; afull_chk = 1'b1; base = wen_count;
    fork
      begin repeat (160) @(posedge wclk); rd_en = 1'b1; end
    join_none
    for (int i = 0; i < 192; i++) send(8'($urandom), i == 191, w);
    t = 0;
    while ((fcnt > 0 || exp_words.size() > 0) && t < 2000) begin idle(1); t++; end
    idle(4);
    check("fifo_drained", fcnt, 0);
    check("fifo_words", wen_count - base, 48);
    check("fifo_saw_afull", saw_afull, 1);
    check("final_pending_words", exp_words.size(), 0);
    check("final_pending_frames", exp_frm.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
